// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: shift-add multiplier and radix-2
// restoring divider behind valid/ready handshakes, with kill for flush.
module muldiv_unit #(
    parameter int XLEN       = 64,
    parameter int MUL_UNROLL = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic            in_is_word,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd,
    output logic            busy
);
    localparam int  XW   = 2 * XLEN;
    localparam int  CW   = 7;
    localparam bit  W_OK = (XLEN == 64);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t          state;
    logic [2:0]      f3;
    logic            word;
    logic            qneg;
    logic            rneg;
    logic [CW-1:0]   cnt;
    logic [XW-1:0]   mcand;
    logic [XW-1:0]   acc;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvsr;

    function automatic logic [XLEN-1:0] sx32(input logic [31:0] x);
        return XLEN'($signed(x));
    endfunction

    logic            accept;
    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic [XLEN-1:0] a_tmp;
    logic [XLEN-1:0] b_tmp;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] min_n;
    logic [XLEN-1:0] ones_n;
    logic            w_bad;
    logic            b_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] spec_res;
    logic [CW-1:0]   iter;

    assign in_ready = (state == S_IDLE) && !reset && !kill;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != S_IDLE);

    // Operand decode, magnitudes and the no-iteration result cases
    always_comb begin
        is_div   = in_funct3[2];
        a_signed = is_div ? !in_funct3[0] : (in_funct3 != 3'd3);
        b_signed = is_div ? !in_funct3[0] : !in_funct3[1];
        a_ext    = in_is_word ? XLEN'(in_rs1[31:0]) : in_rs1;
        b_ext    = in_is_word ? XLEN'(in_rs2[31:0]) : in_rs2;
        a_neg    = a_signed && (in_is_word ? in_rs1[31] : in_rs1[XLEN-1]);
        b_neg    = b_signed && (in_is_word ? in_rs2[31] : in_rs2[XLEN-1]);
        a_tmp    = -a_ext;
        b_tmp    = -b_ext;
        a_mag    = a_ext;
        b_mag    = b_ext;
        if (a_neg) a_mag = in_is_word ? XLEN'(a_tmp[31:0]) : a_tmp;
        if (b_neg) b_mag = in_is_word ? XLEN'(b_tmp[31:0]) : b_tmp;
        min_n    = in_is_word ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        ones_n   = in_is_word ? XLEN'(32'hFFFF_FFFF) : '1;
        w_bad    = in_is_word && (!W_OK || (in_funct3 != 3'd0 && !in_funct3[2]));
        b_zero   = (b_ext == '0);
        ovf      = !in_funct3[0] && (a_ext == min_n) && (b_ext == ones_n);
        special  = w_bad || (is_div && (b_zero || ovf));
        if (w_bad)
            spec_res = '0;
        else if (b_zero)
            spec_res = in_funct3[1] ? (in_is_word ? sx32(in_rs1[31:0]) : in_rs1) : '1;
        else
            spec_res = in_funct3[1] ? '0 : (in_is_word ? sx32(in_rs1[31:0]) : in_rs1);
        if (is_div)
            iter = in_is_word ? CW'(32) : CW'(XLEN);
        else
            iter = in_is_word ? CW'(32 / MUL_UNROLL) : CW'(XLEN / MUL_UNROLL);
    end

    logic [XW-1:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic            ge;
    logic [XLEN-1:0] rem_diff;

    always_comb begin
        mul_sum = acc;
        for (int j = 0; j < MUL_UNROLL; j++)
            if (mplier[j]) mul_sum = mul_sum + (mcand << j);
        rem_sh   = {rem, quo[XLEN-1]};
        ge       = (rem_sh >= {1'b0, dvsr});
        rem_diff = rem_sh[XLEN-1:0] - dvsr;
    end

    logic [XW-1:0]   prod;
    logic [XLEN-1:0] qv;
    logic [XLEN-1:0] rv;
    logic [XLEN-1:0] fix_res;

    always_comb begin
        prod    = qneg ? -acc : acc;
        qv      = qneg ? -quo : quo;
        rv      = rneg ? -rem : rem;
        fix_res = '0;
        unique case (f3)
            3'd0:             fix_res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fix_res = prod[XW-1:XLEN];
            3'd4, 3'd5:       fix_res = qv;
            default:          fix_res = rv;
        endcase
        if (word) fix_res = sx32(fix_res[31:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_rd    <= '0;
        end else if (kill) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (accept) begin
                    f3     <= in_funct3;
                    word   <= in_is_word;
                    out_rd <= in_rd;
                    qneg   <= a_neg ^ b_neg;
                    rneg   <= a_neg;
                    cnt    <= iter - CW'(1);
                    mcand  <= XW'(a_mag);
                    mplier <= b_mag;
                    acc    <= '0;
                    dvsr   <= b_mag;
                    rem    <= '0;
                    // Word dividends are left-aligned so N steps suffice
                    quo    <= in_is_word ? a_mag << (XLEN - 32) : a_mag;
                    if (special) begin
                        out_data  <= spec_res;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= is_div ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    acc    <= mul_sum;
                    mcand  <= mcand << MUL_UNROLL;
                    mplier <= mplier >> MUL_UNROLL;
                    cnt    <= cnt - CW'(1);
                    if (cnt == '0) state <= S_FIX;
                end
                S_DIV: begin
                    rem <= ge ? rem_diff : rem_sh[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], ge};
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) state <= S_FIX;
                end
                S_FIX: begin
                    out_data  <= fix_res;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=64, MUL_UNROLL=4) with an
// arithmetic reference model and a per-cycle output monitor.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = '0;
    logic        in_is_word = 1'b0;
    logic [63:0] in_rs1 = '0;
    logic [63:0] in_rs2 = '0;
    logic [4:0]  in_rd = '0;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        busy;

    muldiv_unit #(.XLEN(64), .MUL_UNROLL(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_is_word(in_is_word),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .kill(kill),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        exp_live = 1'b0;
    logic [63:0] mon_data = '0;
    logic [4:0]  exp_rd = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] f, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [127:0] pa, pb, p;
        logic [31:0]  ua, ub, r32;
        logic signed [31:0] sa32, sb32;
        logic signed [63:0] sa, sb;
        logic ov;
        if (w) begin
            ua = a[31:0]; ub = b[31:0];
            sa32 = $signed(ua); sb32 = $signed(ub);
            ov = (ua == 32'h8000_0000) && (ub == 32'hFFFF_FFFF);
            r32 = '0;
            case (f)
                3'd0: r32 = ua * ub;
                3'd4: if (ub == 0) r32 = '1; else if (ov) r32 = ua; else r32 = sa32 / sb32;
                3'd5: if (ub == 0) r32 = '1; else r32 = ua / ub;
                3'd6: if (ub == 0) r32 = ua; else if (ov) r32 = '0; else r32 = sa32 % sb32;
                3'd7: if (ub == 0) r32 = ua; else r32 = ua % ub;
                default: return 64'd0;
            endcase
            return {{32{r32[31]}}, r32};
        end
        sa = $signed(a); sb = $signed(b);
        ov = (a == 64'h8000_0000_0000_0000) && (b == '1);
        pa = (f == 3'd3) ? {64'd0, a} : {{64{a[63]}}, a};
        pb = (f == 3'd2 || f == 3'd3) ? {64'd0, b} : {{64{b[63]}}, b};
        p  = pa * pb;
        case (f)
            3'd0: return p[63:0];
            3'd1, 3'd2, 3'd3: return p[127:64];
            3'd4: if (b == 0) return '1; else if (ov) return a; else return sa / sb;
            3'd5: if (b == 0) return '1; else return a / b;
            3'd6: if (b == 0) return a; else if (ov) return '0; else return sa % sb;
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    function automatic int lat_model(input logic [2:0] f, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
        logic bz, ov;
        int n;
        n  = w ? 32 : 64;
        bz = w ? (b[31:0] == 0) : (b == 0);
        ov = (f == 3'd4 || f == 3'd6) &&
             (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (w && f >= 3'd1 && f <= 3'd3) return 1;
        if (f[2] && (bz || ov)) return 1;
        return (f[2] ? n : n / 4) + 2;
    endfunction

    // Every cycle a result is presented it must be expected and match the model
    always @(negedge clk) begin
        if (out_valid) begin
            check("mon_live", 64'(exp_live), 64'd1);
            check("mon_data", out_data, mon_data);
            check("mon_rd", 64'(out_rd), 64'(exp_rd));
        end
    end

    task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd);
        mon_data = model(f, w, a, b);
        exp_rd = rd;
        in_funct3 = f; in_is_word = w; in_rs1 = a; in_rs2 = b; in_rd = rd;
        in_valid = 1'b1;
        #1;
        check("accept_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_live = 1'b1;
        cyc = 1;
    endtask

    task automatic wait_valid(input string name, input int lat);
        while (!out_valid && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_lat"}, 64'(cyc), 64'(lat));
    endtask

    task automatic finish_op(input string name, input logic [63:0] lit,
                             input logic [4:0] rd, input int hold);
        check({name, "_data"}, out_data, lit);
        check({name, "_rd"}, 64'(out_rd), 64'(rd));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({name, "_hold_inready"}, 64'(in_ready), 64'd0);
            check({name, "_hold_data"}, out_data, lit);
            check({name, "_hold_rd"}, 64'(out_rd), 64'(rd));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_live = 1'b0;
        #1;
        check({name, "_drop"}, 64'(out_valid), 64'd0);
        check({name, "_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run(input string name, input logic [2:0] f, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                       input logic [63:0] lit, input int lat, input int hold);
        issue(f, w, a, b, rd);
        wait_valid(name, lat);
        finish_op(name, lit, rd, hold);
    endtask

    initial begin
        int vlo;
        logic [2:0] rf;
        logic [63:0] ra, rb;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_rd", 64'(out_rd), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_inready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_inready", 64'(in_ready), 64'd1);

        run("mul", 3'd0, 0, 64'd7, -64'sd3, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 18, 0);
        run("mulhu", 3'd3, 0, '1, 64'd2, 5'd6, 64'd1, 18, 0);
        run("mulh", 3'd1, 0, '1, '1, 5'd7, 64'd0, 18, 0);
        run("mulhsu", 3'd2, 0, '1, 64'd2, 5'd8, '1, 18, 0);
        run("div", 3'd4, 0, -64'sd7, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
        run("rem", 3'd6, 0, -64'sd7, 64'd2, 5'd10, '1, 66, 0);
        run("divu", 3'd5, 0, 64'd100, 64'd7, 5'd11, 64'd14, 66, 0);
        run("remu", 3'd7, 0, 64'd100, 64'd7, 5'd12, 64'd2, 66, 0);
        run("div0", 3'd4, 0, 64'd5, 64'd0, 5'd13, '1, 1, 0);
        run("rem0", 3'd6, 0, 64'd5, 64'd0, 5'd14, 64'd5, 1, 0);
        run("divovf", 3'd4, 0, 64'h8000_0000_0000_0000, '1, 5'd15,
            64'h8000_0000_0000_0000, 1, 0);
        run("removf", 3'd6, 0, 64'h8000_0000_0000_0000, '1, 5'd16, 64'd0, 1, 0);
        run("divwovf", 3'd4, 1, 64'h8000_0000, '1, 5'd17, 64'hFFFF_FFFF_8000_0000, 1, 0);
        run("mulw", 3'd0, 1, 64'h1_0000, 64'h1_0000, 5'd18, 64'd0, 10, 0);
        run("divuw", 3'd5, 1, 64'hFFFF_FFFE, 64'd1, 5'd19, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0);
        run("remw", 3'd6, 1, 64'h1_0000_0005, 64'd3, 5'd20, 64'd2, 34, 0);
        run("divw", 3'd4, 1, 64'hFFFF_FFF9, 64'd2, 5'd21, 64'hFFFF_FFFF_FFFF_FFFD, 34, 0);
        run("mulhw_ill", 3'd1, 1, 64'd9, 64'd9, 5'd22, 64'd0, 1, 0);
        run("divw0", 3'd4, 1, 64'd5, 64'h1_0000_0000, 5'd23, '1, 1, 0);
        run("remuw0", 3'd7, 1, 64'h1_8000_0000, 64'h1_0000_0000, 5'd24,
            64'hFFFF_FFFF_8000_0000, 1, 0);
        run("bp", 3'd0, 0, 64'd6, 64'd7, 5'd25, 64'd42, 18, 5);

        // Kill a divide in flight
        issue(3'd4, 0, 64'd1000, 64'd3, 5'd26);
        repeat (19) begin @(posedge clk); #1; end
        kill = 1'b1;
        #1;
        check("kill_inready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        kill = 1'b0;
        exp_live = 1'b0;
        #1;
        check("kill_ready", 64'(in_ready), 64'd1);
        check("kill_busy", 64'(busy), 64'd0);
        vlo = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) vlo++;
        end
        check("kill_novalid", 64'(vlo), 64'd0);
        run("after_kill", 3'd0, 0, 64'd3, 64'd4, 5'd27, 64'd12, 18, 0);

        // Kill in DONE beats a simultaneous handshake
        issue(3'd0, 0, 64'd2, 64'd3, 5'd28);
        wait_valid("killdone", 18);
        kill = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        out_ready = 1'b0;
        exp_live = 1'b0;
        #1;
        check("killdone_valid", 64'(out_valid), 64'd0);
        check("killdone_ready", 64'(in_ready), 64'd1);

        // Kill with in_valid in IDLE accepts nothing
        in_funct3 = 3'd0; in_is_word = 1'b0; in_rs1 = 64'd1; in_rs2 = 64'd1;
        in_valid = 1'b1;
        kill = 1'b1;
        #1;
        check("killidle_inready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        kill = 1'b0;
        #1;
        check("killidle_busy", 64'(busy), 64'd0);

        // Reset mid-multiply
        issue(3'd0, 0, 64'd11, 64'd13, 5'd29);
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstmid_valid", 64'(out_valid), 64'd0);
        check("rstmid_data", out_data, 64'd0);
        check("rstmid_rd", 64'(out_rd), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        exp_live = 1'b0;
        #1;

        for (int i = 0; i < 16; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = {$urandom, $urandom};
            rb = (i % 3 == 0) ? 64'($urandom_range(0, 5)) : {$urandom, $urandom};
            if (i % 5 == 1) ra = -ra;
            run($sformatf("rnd%0d", i), rf, 1'(i % 2), ra, rb, 5'(i),
                model(rf, 1'(i % 2), ra, rb), lat_model(rf, 1'(i % 2), ra, rb), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
